// File: rtl/rv_core_pkg.sv
// Shared RV32I core constants.
//   XLEN      : datapath width of pc / instruction words
//   RV_NOP    : canonical nop (addi x0, x0, 0)
//   RESET_PC  : pc the fetch stage starts from after reset
package rv_core_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RV_NOP   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/queue_ptr_ctrl.sv
// Generic circular-queue bookkeeping: read/write pointers, occupancy count,
// full/empty flags. Storage lives in the instantiating module.
//   clk, rst     : clock, synchronous active-high reset
//   push, pop    : qualified enqueue / dequeue strobes for this cycle
//   flush        : drop all entries on the next edge
//   wr_ptr       : slot the next push writes
//   rd_ptr       : slot currently at the head
//   count        : registered occupancy, 0..DEPTH
//   full, empty  : decoded from count
module queue_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/instr_queue.sv
// Fetch -> decode instruction queue. Buffers up to DEPTH {pc, instr} pairs,
// presents them in order over valid/ready, and discards everything on a
// redirect (flush).
// Optional feature: define INSTR_QUEUE_BYPASS_EN to let an empty queue pass
// the incoming pair straight to the output in the same cycle.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : fetch presents a pair
//   in_ready      : queue accepts (not full, not in reset)
//   in_pc/in_instr: incoming pair
//   flush         : taken jump/branch; wrong-path entries dropped
//   out_valid     : head available (forced low by flush)
//   out_ready     : decode consumes head
//   out_pc/instr  : head pair
//   out_misalign  : head pc not word aligned, qualified by out_valid
//   count         : occupancy
module instr_queue
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv_core_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] last_pc, last_instr;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic          byp, byp_take, push, pop;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign byp = empty & in_valid & ~flush & ~rst;
`else
  assign byp = 1'b0;
`endif
  // A bypassed pair that decode takes immediately never enters storage.
  assign byp_take  = byp & out_ready;

  assign in_ready  = ~rst & ~full;
  assign out_valid = ~flush & (~empty | byp);
  assign push      = in_valid & in_ready & ~flush & ~byp_take;
  assign pop       = out_valid & out_ready & ~empty;

  queue_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // When the queue drains the output keeps showing the last head it read,
  // not whatever stale slot rd_ptr now points at.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else if (!empty) begin
      last_pc    <= pc_mem[rd_ptr];
      last_instr <= instr_mem[rd_ptr];
    end
  end

  always_comb begin
    out_pc    = empty ? last_pc    : pc_mem[rd_ptr];
    out_instr = empty ? last_instr : instr_mem[rd_ptr];
    if (byp) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  assign out_misalign = out_valid & (out_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, out_valid, out_ready, out_misalign;
  logic [XLEN-1:0] in_pc, in_instr, out_pc, out_instr;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;
  int mcnt     = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_misalign (out_misalign),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // One cycle: drive inputs, check against the scoreboard model, advance.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic fl, input logic rdy);
    logic exp_byp, exp_valid, do_pop, do_push;
    logic [31:0] hpc, hins;
    in_valid = v; in_pc = pc; in_instr = ins; flush = fl; out_ready = rdy;
    #2;
    exp_byp = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    exp_byp = (mcnt == 0) && v && !fl;
`endif
    exp_valid = !fl && (mcnt > 0 || exp_byp);
    chk("in_ready", {31'b0, in_ready}, {31'b0, mcnt < DEPTH});
    chk("count", {29'b0, count}, mcnt);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      hpc  = (mcnt > 0) ? sb[0][63:32] : pc;
      hins = (mcnt > 0) ? sb[0][31:0]  : ins;
      chk("out_pc", out_pc, hpc);
      chk("out_instr", out_instr, hins);
      chk("out_misalign", {31'b0, out_misalign}, {31'b0, hpc[1:0] != 2'b00});
    end else begin
      chk("out_misalign", {31'b0, out_misalign}, 32'd0);
    end
    do_pop  = exp_valid && rdy && (mcnt > 0);
    do_push = v && (mcnt < DEPTH) && !fl && !(exp_byp && rdy);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back({pc, ins});
    if (fl)      sb.delete();
    mcnt = sb.size();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h13;
    flush = 1'b0; out_ready = 1'b0;
    // reset held 3 cycles with fetch asserting valid
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // fill to full, try one push while full, then drain
    step(1'b1, 32'h0, 32'h13,  1'b0, 1'b0);
    step(1'b1, 32'h4, 32'h93,  1'b0, 1'b0);
    step(1'b1, 32'h8, 32'h113, 1'b0, 1'b0);
    step(1'b1, 32'hC, 32'h193, 1'b0, 1'b0);
    step(1'b1, 32'h999, 32'hdead, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drain_hold_pc", out_pc, 32'hC);

    // wrap: concurrent push/pop from count=1
    step(1'b1, 32'h0, 32'h1000, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, 32'(i * 4), 32'(32'h1000 + i), 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // flush with concurrent push
    step(1'b1, 32'h300, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h304, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h100, 32'h6, 1'b1, 1'b1);
    step(1'b1, 32'h200, 32'h7, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // flush held two cycles
    step(1'b1, 32'h400, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'h9, 1'b1, 1'b0);
    step(1'b1, 32'h408, 32'hA, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // misalign
    step(1'b1, 32'h102, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // empty queue, push with decode ready (same-cycle under bypass)
    step(1'b1, 32'h40, 32'hD, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    // empty queue, push with decode stalled
    step(1'b1, 32'h44, 32'hE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // reset mid-operation drops entries
    step(1'b1, 32'h600, 32'hF, 1'b0, 1'b0);
    step(1'b1, 32'h604, 32'h10, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h608; out_ready = 1'b0;
    #2;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); mcnt = 0;
    chk("midrst_out_pc", out_pc, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h700, 32'h11, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the fetch stage and decode in the single-cycle/pipelined RV32I core. It accepts one {pc, instruction} pair per cycle from the fetch path (`addr_instr` plus instruction-memory read data) and buffers up to DEPTH entries. Entries are presented in order to decode over a valid/ready handshake. Any taken jump or branch (`jmp_en | jmpr_en | jmpb_en`) flushes all buffered wrong-path entries.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of pc and instruction fields

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a pair this cycle
- in_ready  out  1  queue can accept; `count < DEPTH` and not `rst`
- in_pc  in  XLEN  pc of fetched instruction
- in_instr  in  XLEN  fetched instruction word
- flush  in  1  redirect (OR of `jmp_en`, `jmpr_en`, `jmpb_en`); discard all entries
- out_valid  out  1  head entry available; masked by `flush`
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  XLEN  pc of head entry
- out_instr  out  XLEN  instruction of head entry
- out_misalign  out  1  `out_pc[1:0] != 0`, qualified by `out_valid`
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with `wr_ptr`, `rd_ptr`, and a registered `count`. Pointers wrap modulo DEPTH.
- **Push:** occurs when `in_valid & in_ready & !flush`. The entry is written at `wr_ptr`, then `wr_ptr` is incremented.
- **Pop:** occurs when `out_valid & out_ready`. `rd_ptr` is incremented.
- **Count update:** `count += push - pop`. A simultaneous push and pop leaves `count` unchanged. This is legal at any occupancy below DEPTH.
- **Full:** when `count == DEPTH`, `in_ready` is 0 and fetch holds. A pop while full does not raise `in_ready` in the same cycle; it rises the next cycle.
- **Empty:** when `count == 0`, `out_valid` is 0 and `out_pc`/`out_instr` hold the last value read from storage.
- **Flush priority:** in the cycle `flush` is high:
  - the push is dropped;
  - `out_valid` is forced to 0, so no pop occurs;
  - on the next edge, `count`, `wr_ptr`, and `rd_ptr` are set to 0.
- `flush` held for multiple cycles keeps the queue empty.
- **Reset:** all pointers and `count` are set to 0, and storage is cleared to 0. Reset mid-operation discards entries exactly like a flush.

## Timing
- Reset values: in_ready=0 while rst=1, then 1; out_valid=0; out_pc=0; out_instr=0; out_misalign=0; count=0.
- Latency without bypass: an entry pushed at edge N is visible at `out_*` with `out_valid=1` in the cycle after edge N.
- Throughput: one push and one pop per cycle sustained.
- `in_ready` depends only on registered `count` and `rst`. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` has a combinational path from `flush`. Decode must not feed `flush` back from `out_*` in the same cycle.

## Configuration
- Macro: `INSTR_QUEUE_BYPASS_EN`.
- **Defined:** when `count == 0` and `in_valid & !flush`, the output presents `in_pc`/`in_instr` combinationally, with `out_valid=1`, in the same cycle.
  - If `out_ready=1`, the pair is consumed without being written, and `count` stays 0.
  - If `out_ready=0`, the pair is written normally.
- **Undefined:** there is no bypass, and the minimum latency is 1 cycle.

## Structure
- Shared package/header `rv_core_pkg` holds:
  - `XLEN`;
  - `RV_NOP` = 32'h0000_0013;
  - the reset pc constant.
- `instr_queue` has no local typedefs.
- Sub-module `queue_ptr_ctrl` implements the pointer/count/full/empty logic. It is parameterised by DEPTH and reusable for the later load/store queue.
- Storage is a flat register array in the top module.

## Test plan
- **Reset:** hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0, count=0, out_pc=0. After rst drops, in_ready=1.
- **Fill/drain:** out_ready=0; push pcs 0x0, 0x4, 0x8, 0xC with instrs 0x13, 0x93, 0x113, 0x193 → count=4, in_ready=0. Then out_ready=1 → pops in order, one per cycle; count reaches 0; out_valid=0.
- **Wrap:** with DEPTH=4, perform 10 pushes with a concurrent pop every cycle from count=1 → count stays 1, all pcs 0x0..0x24 emerge in order, no loss across pointer wrap.
- **Flush with push:** count=3, flush=1 with in_valid=1 (pc 0x100) → out_valid=0 that cycle, count=0 next cycle, pc 0x100 never appears. The next push (pc 0x200) appears first.
- **Misalign:** push pc 0x102 → out_misalign=1 with out_valid=1. Push pc 0x104 → out_misalign=0.
- **Bypass (`INSTR_QUEUE_BYPASS_EN`):** empty queue, in_valid=1, pc 0x40, out_ready=1 → out_valid=1, out_pc=0x40 in the same cycle, count remains 0.
